adc_capture_buffer: RTL and testbench

Upstream acquisition stage feeding the FT245 streaming controller. On a one-cycle START_TURN pulse it generates a divided ADC sample clock and flushes the ADC pipeline. It then captures SAMPLING_NUM words of {OTR, 12-bit sample} into an internal RAM and pulses TURN_DONE. The controller then reads the RAM through a synchronous read port.

---
 rtl/adc_capture_pkg.sv | 32 +++
 rtl/adc_clk_gen.sv | 49 ++++
 rtl/adc_capture_buffer.sv | 129 ++++++++++++
 tb/tb_adc_capture_buffer.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/adc_capture_pkg.sv
// Shared types and sample-word layout for the ADC capture buffer.
// The state encoding, word bit positions and default turn length live here.
package adc_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WARMUP  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  localparam int unsigned WORD_WIDTH           = 16;
  localparam int unsigned DATA_WIDTH           = 12;
  localparam int unsigned OTR_BIT              = 15;
  localparam int unsigned PAD_MSB              = 14;
  localparam int unsigned PAD_LSB              = 12;
  localparam int unsigned DATA_MSB             = 11;
  localparam int unsigned DATA_LSB             = 0;
  localparam int unsigned DEFAULT_SAMPLING_NUM = 1000;

  // Builds one RAM word: {OTR, 3'b000, sample}.
  function automatic logic [WORD_WIDTH-1:0] pack_sample(input logic otr,
                                                        input logic [DATA_WIDTH-1:0] data);
    logic [WORD_WIDTH-1:0] w;
    w                   = '0;
    w[OTR_BIT]          = otr;
    w[PAD_MSB:PAD_LSB]  = '0;
    w[DATA_MSB:DATA_LSB] = data;
    return w;
  endfunction

endpackage

// File: rtl/adc_clk_gen.sv
// Divided ADC sample clock: toggles every div_i cycles while enabled.
// Strobes flag the cycle whose closing edge makes ADC_CLK rise or fall.
module adc_clk_gen #(
  parameter int unsigned DIV_WIDTH = 11
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  output logic                 adc_clk_o,
  output logic                 rise_stb_c,
  output logic                 fall_stb_c
);

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic                 adc_clk_q, adc_clk_d;
  logic                 toggle_c;

  // div_i is never 0 here; the top clamps it when latching.
  assign toggle_c   = en_i && (cnt_q == (div_i - DIV_WIDTH'(1)));
  assign rise_stb_c = toggle_c && !adc_clk_q;
  assign fall_stb_c = toggle_c && adc_clk_q;
  assign adc_clk_o  = adc_clk_q;

  always_comb begin
    cnt_d     = cnt_q;
    adc_clk_d = adc_clk_q;
    if (!en_i) begin
      cnt_d     = '0;
      adc_clk_d = 1'b0;
    end else if (toggle_c) begin
      cnt_d     = '0;
      adc_clk_d = ~adc_clk_q;
    end else begin
      cnt_d = cnt_q + DIV_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      adc_clk_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      adc_clk_q <= adc_clk_d;
    end
  end

endmodule

// File: rtl/adc_capture_buffer.sv
// One capture turn: warm up the ADC pipeline, store SAMPLING_NUM words in RAM,
// pulse TURN_DONE; the RAM is read back through a registered read port.
module adc_capture_buffer
  import adc_capture_pkg::*;
#(
  parameter int unsigned SAMPLING_NUM = DEFAULT_SAMPLING_NUM,
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned PIPE_DELAY   = 3,
  parameter int unsigned DIV_WIDTH    = 11
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START_TURN,
  input  logic [DIV_WIDTH-1:0]  DIVIDER,
  input  logic [11:0]           ADC_BIT,
  input  logic                  ADC_OTR,
  output logic                  ADC_CLK,
  output logic                  ADC_OE,
  input  logic [ADDR_WIDTH-1:0] RAM_RD_ADDR,
  output logic [15:0]           RAM_DATA_OUT,
  output logic                  TURN_DONE,
  output logic                  BUSY
);

  localparam int unsigned DEPTH     = 1 << ADDR_WIDTH;
  localparam int unsigned FCW       = $clog2(PIPE_DELAY + 1) + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(SAMPLING_NUM - 1);
  localparam logic [FCW-1:0]        LAST_FALL = FCW'(PIPE_DELAY - 1);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [FCW-1:0]          fall_cnt_q, fall_cnt_d;
  logic [DIV_WIDTH-1:0]    div_q, div_d;
  logic                    busy_q, busy_d;
  logic                    oe_n_q, oe_n_d;
  logic                    done_q, done_d;
  logic                    we_c;
  logic                    clk_en_c;
  logic                    rise_stb, fall_stb;
  logic [WORD_WIDTH-1:0]   mem_q [DEPTH];
  logic [WORD_WIDTH-1:0]   rd_data_q;

  assign clk_en_c = (state_q == ST_WARMUP) || (state_q == ST_CAPTURE);

  adc_clk_gen #(.DIV_WIDTH(DIV_WIDTH)) u_clk_gen (
    .clk_i      (CLK),
    .rst_i      (RST),
    .en_i       (clk_en_c),
    .div_i      (div_q),
    .adc_clk_o  (ADC_CLK),
    .rise_stb_c (rise_stb),
    .fall_stb_c (fall_stb)
  );

  // Turn sequencing and registered-output lookahead.
  always_comb begin
    state_d    = state_q;
    wr_addr_d  = wr_addr_q;
    fall_cnt_d = fall_cnt_q;
    div_d      = div_q;
    we_c       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (START_TURN) begin
          div_d      = (DIVIDER == '0) ? DIV_WIDTH'(1) : DIVIDER;
          wr_addr_d  = '0;
          fall_cnt_d = '0;
          state_d    = (PIPE_DELAY == 0) ? ST_CAPTURE : ST_WARMUP;
        end
      end
      ST_WARMUP: begin
        if (fall_stb) begin
          if (fall_cnt_q == LAST_FALL) state_d = ST_CAPTURE;
          else                         fall_cnt_d = fall_cnt_q + FCW'(1);
        end
      end
      ST_CAPTURE: begin
        if (fall_stb) begin
          we_c = 1'b1;
          if (wr_addr_q == LAST_ADDR) state_d = ST_DONE;
          else                        wr_addr_d = wr_addr_q + ADDR_WIDTH'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_WARMUP) || (state_d == ST_CAPTURE);
    oe_n_d = !busy_d;
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      wr_addr_q  <= '0;
      fall_cnt_q <= '0;
      div_q      <= DIV_WIDTH'(1);
      busy_q     <= 1'b0;
      oe_n_q     <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_addr_q  <= wr_addr_d;
      fall_cnt_q <= fall_cnt_d;
      div_q      <= div_d;
      busy_q     <= busy_d;
      oe_n_q     <= oe_n_d;
      done_q     <= done_d;
    end
  end

  // Simple dual-port RAM; the read register returns pre-write data on a collision.
  always_ff @(posedge CLK) begin
    if (we_c && !RST) mem_q[wr_addr_q] <= pack_sample(ADC_OTR, ADC_BIT);
  end

  always_ff @(posedge CLK) begin
    if (RST) rd_data_q <= '0;
    else     rd_data_q <= mem_q[RAM_RD_ADDR];
  end

  assign BUSY         = busy_q;
  assign ADC_OE       = oe_n_q;
  assign TURN_DONE    = done_q;
  assign RAM_DATA_OUT = rd_data_q;

  a_strobes_exclusive: assert property (@(posedge CLK) disable iff (RST) !(rise_stb && fall_stb));

endmodule

// File: tb/tb_adc_capture_buffer.sv
// Directed bench for adc_capture_buffer with a falling-edge ADC code model.
module tb_adc_capture_buffer;

  localparam int N = 4;
  localparam int P = 3;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        START_TURN = 1'b0;
  logic [10:0] DIVIDER = 11'd2;
  logic [11:0] ADC_BIT;
  logic        ADC_OTR;
  logic        ADC_CLK;
  logic        ADC_OE;
  logic [9:0]  RAM_RD_ADDR = 10'd0;
  logic [15:0] RAM_DATA_OUT;
  logic        TURN_DONE;
  logic        BUSY;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  logic        model_clear = 1'b0;
  int          fall_seen = 0;
  logic        prev_clk = 1'b0;
  logic [11:0] code_base = 12'h000;
  int          otr_at = 0;

  adc_capture_buffer #(
    .SAMPLING_NUM(N), .ADDR_WIDTH(10), .PIPE_DELAY(P), .DIV_WIDTH(11)
  ) dut (
    .CLK(CLK), .RST(RST), .START_TURN(START_TURN), .DIVIDER(DIVIDER),
    .ADC_BIT(ADC_BIT), .ADC_OTR(ADC_OTR), .ADC_CLK(ADC_CLK), .ADC_OE(ADC_OE),
    .RAM_RD_ADDR(RAM_RD_ADDR), .RAM_DATA_OUT(RAM_DATA_OUT),
    .TURN_DONE(TURN_DONE), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // ADC model: code k is presented until falling edge k samples it.
  always @(negedge CLK) begin
    if (model_clear) fall_seen = 0;
    else if (prev_clk && !ADC_CLK) fall_seen++;
    prev_clk = ADC_CLK;
    if (otr_at != 0 && fall_seen + 1 == otr_at) begin
      ADC_OTR = 1'b1;
      ADC_BIT = 12'hFFF;
    end else begin
      ADC_OTR = 1'b0;
      ADC_BIT = code_base + 12'(fall_seen + 1);
    end
  end

  task automatic run_turn(input string name, input logic [10:0] div, input int d,
                          input int collide, input int rst_at);
    int   t, last, dones, exp_dones;
    logic aborted, active, exp_clk;
    model_clear = 1'b1;
    repeat (2) @(negedge CLK);
    model_clear = 1'b0;
    DIVIDER    = div;
    START_TURN = 1'b1;
    t     = cyc;
    last  = t + 2 * d * (P + N);
    dones = 0;
    for (int k = t + 1; k <= last + 10; k++) begin
      @(negedge CLK);
      aborted = (rst_at != 0) && (k > t + rst_at);
      active  = !aborted && (k <= last);
      exp_clk = active ? (((k - t - 1) / d) % 2 == 1) : 1'b0;
      vectors += 4;
      if (BUSY !== active) begin
        miscompares++;
        $display("FAIL %s BUSY at t+%0d: got %b want %b", name, k - t, BUSY, active);
      end
      if (ADC_OE !== !active) begin
        miscompares++;
        $display("FAIL %s ADC_OE at t+%0d: got %b want %b", name, k - t, ADC_OE, !active);
      end
      if (ADC_CLK !== exp_clk) begin
        miscompares++;
        $display("FAIL %s ADC_CLK at t+%0d: got %b want %b", name, k - t, ADC_CLK, exp_clk);
      end
      if (TURN_DONE !== (!aborted && k == last + 1)) begin
        miscompares++;
        $display("FAIL %s TURN_DONE at t+%0d: got %b want %b", name, k - t, TURN_DONE,
                 (!aborted && k == last + 1));
      end
      if (TURN_DONE === 1'b1) dones++;
      START_TURN = (collide != 0) && (k == t + 5);
      if (collide != 0 && k == t + 6) DIVIDER = 11'd7;
      RST = (rst_at != 0) && (k == t + rst_at);
    end
    RST = 1'b0;
    exp_dones = (rst_at != 0) ? 0 : 1;
    vectors++;
    if (dones != exp_dones) begin
      miscompares++;
      $display("FAIL %s done_count: got %0d want %0d", name, dones, exp_dones);
    end
  endtask

  task automatic check_words(input string name, input logic [15:0] w0, input logic [15:0] w1,
                             input logic [15:0] w2, input logic [15:0] w3);
    logic [15:0] exp_w [4];
    exp_w = '{w0, w1, w2, w3};
    @(negedge CLK);
    RAM_RD_ADDR = 10'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      vectors++;
      if (RAM_DATA_OUT !== exp_w[i]) begin
        miscompares++;
        $display("FAIL %s RAM[%0d]: got %h want %h", name, i, RAM_DATA_OUT, exp_w[i]);
      end
      RAM_RD_ADDR = 10'(i + 1);
    end
  endtask

  task automatic test_reset;
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    vectors += 5;
    if (BUSY !== 1'b0)         begin miscompares++; $display("FAIL reset BUSY: got %b want 0", BUSY); end
    if (ADC_OE !== 1'b1)       begin miscompares++; $display("FAIL reset ADC_OE: got %b want 1", ADC_OE); end
    if (ADC_CLK !== 1'b0)      begin miscompares++; $display("FAIL reset ADC_CLK: got %b want 0", ADC_CLK); end
    if (TURN_DONE !== 1'b0)    begin miscompares++; $display("FAIL reset TURN_DONE: got %b want 0", TURN_DONE); end
    if (RAM_DATA_OUT !== 16'h0) begin miscompares++; $display("FAIL reset RAM_DATA_OUT: got %h want 0000", RAM_DATA_OUT); end
    RST = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_basic;
    code_base = 12'h000;
    otr_at    = 0;
    run_turn("basic", 11'd2, 2, 0, 0);
    check_words("basic_read", 16'h0004, 16'h0005, 16'h0006, 16'h0007);
  endtask

  task automatic test_otr;
    otr_at = 5;
    run_turn("otr", 11'd2, 2, 0, 0);
    check_words("otr_read", 16'h0004, 16'h8FFF, 16'h0006, 16'h0007);
    otr_at = 0;
  endtask

  task automatic test_div_zero;
    code_base = 12'h020;
    run_turn("div0", 11'd0, 1, 0, 0);
    check_words("div0_read", 16'h0024, 16'h0025, 16'h0026, 16'h0027);
  endtask

  task automatic test_busy_collision;
    code_base = 12'h000;
    run_turn("collide", 11'd2, 2, 1, 0);
    DIVIDER = 11'd2;
  endtask

  task automatic test_reset_mid_capture;
    code_base = 12'h000;
    run_turn("rst_mid", 11'd2, 2, 0, 20);
    code_base = 12'h100;
    run_turn("after_rst", 11'd2, 2, 0, 0);
    check_words("after_rst_read", 16'h0104, 16'h0105, 16'h0106, 16'h0107);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_otr();
    test_div_zero();
    test_busy_collision();
    test_reset_mid_capture();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
